// File: rtl/hp_manager.sv
// Two-player health manager: latches attack requests, applies damage with dodge
// halving and saturation, holds knockback until buttons are released, and
// declares the winner once a player's health reaches zero.
// Optional feature: define HP_COOLDOWN_EN to add a per-player lockout after
// each landed hit.
module hp_manager #(
   parameter int HP_MAX    = 200,
   parameter int HP_W      = 8,
   parameter int KICK_DMG  = 14,
   parameter int FIGHT_DMG = 8,
   parameter int JUMP_DMG  = 20,
   parameter int KB_CYCLES = 8,
   parameter int COOLDOWN  = 16,
   parameter int HP1_X0    = 75,
   parameter int HP2_X0    = 364
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [2:0]      atk1,
   input  logic            valid1,
   input  logic            dodge1,
   input  logic [2:0]      atk2,
   input  logic            valid2,
   input  logic            dodge2,
   output logic [HP_W-1:0] hp1,
   output logic [HP_W-1:0] hp2,
   output logic [9:0]      hp1x,
   output logic [9:0]      hp2x,
   output logic [1:0]      back1,
   output logic [1:0]      back2,
   output logic            hit1,
   output logic            hit2,
   output logic            p1win,
   output logic            p2win,
   output logic            draw
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] APPLY = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [1:0] OVER  = 2'd3;

   localparam int KB_W = $clog2(KB_CYCLES + 1);
   localparam int X1   = HP1_X0 + HP_MAX;

   logic [1:0]      state;
   logic            lat1, lat2;
   logic [2:0]      typ1, typ2;      // one-hot latched attack type
   logic [KB_W-1:0] kb_cnt;
   logic            cd_ok1, cd_ok2;
   logic            acc1, acc2, released;
   logic [HP_W-1:0] dmg_to1, dmg_to2, hp1_new, hp2_new;

   // Reduce a raw button vector to a one-hot type, kick > fight > jump.
   function automatic logic [2:0] prio(input logic [2:0] a);
      if (a[0])      return 3'b001;
      else if (a[1]) return 3'b010;
      else if (a[2]) return 3'b100;
      else           return 3'b000;
   endfunction

   function automatic logic [HP_W-1:0] base_dmg(input logic [2:0] t);
      if (t[0])      return HP_W'(KICK_DMG);
      else if (t[1]) return HP_W'(FIGHT_DMG);
      else if (t[2]) return HP_W'(JUMP_DMG);
      else           return '0;
   endfunction

`ifdef HP_COOLDOWN_EN
   localparam int CD_W = $clog2(COOLDOWN + 1);
   logic [CD_W-1:0] cd1, cd2;

   // Lockout counters: load on a landed hit, then count down to zero.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cd1 <= '0;
         cd2 <= '0;
      end else begin
         if (state == APPLY && lat1) cd1 <= CD_W'(COOLDOWN);
         else if (cd1 != '0)         cd1 <= cd1 - 1'b1;
         if (state == APPLY && lat2) cd2 <= CD_W'(COOLDOWN);
         else if (cd2 != '0)         cd2 <= cd2 - 1'b1;
      end
   end

   assign cd_ok1 = (cd1 == '0);
   assign cd_ok2 = (cd2 == '0);
`else
   assign cd_ok1 = 1'b1;
   assign cd_ok2 = 1'b1;
`endif

   // Request acceptance, damage and release detection.
   always_comb begin
      acc1     = (state == IDLE) && valid1 && (atk1 != 3'b000) && cd_ok1;
      acc2     = (state == IDLE) && valid2 && (atk2 != 3'b000) && cd_ok2;
      dmg_to2  = lat1 ? (dodge2 ? (base_dmg(typ1) >> 1) : base_dmg(typ1)) : '0;
      dmg_to1  = lat2 ? (dodge1 ? (base_dmg(typ2) >> 1) : base_dmg(typ2)) : '0;
      hp1_new  = (hp1 <= dmg_to1) ? '0 : hp1 - dmg_to1;
      hp2_new  = (hp2 <= dmg_to2) ? '0 : hp2 - dmg_to2;
      // Only the button that caused the latched attack must be let go.
      released = !(lat1 && ((atk1 & typ1) != 3'b000)) &&
                 !(lat2 && ((atk2 & typ2) != 3'b000));
   end

   // Main FSM with health, knockback and hit-pulse registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         hp1    <= HP_W'(HP_MAX);
         hp2    <= HP_W'(HP_MAX);
         back1  <= 2'b00;
         back2  <= 2'b00;
         hit1   <= 1'b0;
         hit2   <= 1'b0;
         lat1   <= 1'b0;
         lat2   <= 1'b0;
         typ1   <= 3'b000;
         typ2   <= 3'b000;
         kb_cnt <= '0;
      end else begin
         hit1 <= 1'b0;
         hit2 <= 1'b0;
         case (state)
            IDLE: begin
               if (acc1 || acc2) begin
                  lat1  <= acc1;
                  lat2  <= acc2;
                  typ1  <= acc1 ? prio(atk1) : 3'b000;
                  typ2  <= acc2 ? prio(atk2) : 3'b000;
                  state <= APPLY;
               end
            end
            APPLY: begin
               hp1 <= hp1_new;
               hp2 <= hp2_new;
               if (lat2) begin
                  back1 <= dodge1 ? 2'b01 : 2'b10;
                  hit1  <= 1'b1;
               end
               if (lat1) begin
                  back2 <= dodge2 ? 2'b01 : 2'b10;
                  hit2  <= 1'b1;
               end
               kb_cnt <= KB_W'(KB_CYCLES - 1);
               state  <= (hp1_new == '0 || hp2_new == '0) ? OVER : HOLD;
            end
            HOLD: begin
               if (kb_cnt != '0) begin
                  kb_cnt <= kb_cnt - 1'b1;
               end else if (released) begin
                  back1 <= 2'b00;
                  back2 <= 2'b00;
                  lat1  <= 1'b0;
                  lat2  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: ;  // OVER is sticky until Reset
         endcase
      end
   end

   // Result flags and health-bar positions.
   always_comb begin
      p1win = (state == OVER) && (hp2 == '0) && (hp1 != '0);
      p2win = (state == OVER) && (hp1 == '0) && (hp2 != '0);
      draw  = (state == OVER) && (hp1 == '0) && (hp2 == '0);
      hp1x  = 10'(X1) - 10'(hp1);
      hp2x  = 10'(HP2_X0) + 10'(hp2);
   end

endmodule

// File: tb/tb_hp_manager.sv
// Directed bench for hp_manager: a vector table of single attacks plus
// hand-written sequences for hold/release, HOLD blocking, game over, draw and
// mid-attack reset.
module tb_hp_manager;

   localparam int KB = 8;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [2:0] atk1 = 3'b000, atk2 = 3'b000;
   logic       valid1 = 1'b0, valid2 = 1'b0, dodge1 = 1'b0, dodge2 = 1'b0;
   logic [7:0] hp1, hp2;
   logic [9:0] hp1x, hp2x;
   logic [1:0] back1, back2;
   logic       hit1, hit2, p1win, p2win, draw;

   int n_vec  = 0;
   int n_fail = 0;

   hp_manager dut (
      .Clk(Clk), .Reset(Reset),
      .atk1(atk1), .valid1(valid1), .dodge1(dodge1),
      .atk2(atk2), .valid2(valid2), .dodge2(dodge2),
      .hp1(hp1), .hp2(hp2), .hp1x(hp1x), .hp2x(hp2x),
      .back1(back1), .back2(back2), .hit1(hit1), .hit2(hit2),
      .p1win(p1win), .p2win(p2win), .draw(draw)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [2:0] a1;
      logic       v1;
      logic       d1;
      logic [2:0] a2;
      logic       v2;
      logic       d2;
      int         e_hp1;
      int         e_hp2;
      logic [1:0] e_b1;
      logic [1:0] e_b2;
      logic       e_h1;
      logic       e_h2;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clr_in();
      atk1 = 3'b000; valid1 = 1'b0; dodge1 = 1'b0;
      atk2 = 3'b000; valid2 = 1'b0; dodge2 = 1'b0;
   endtask

   task automatic do_reset();
      clr_in();
      Reset = 1'b1;
      step();
      step();
      Reset = 1'b0;
      step();
   endtask

   // who: 1 = P1 attacks, 2 = P2 attacks, 3 = both; dg is the defenders' dodge.
   task automatic attack(input int who, input logic [2:0] a, input logic dg);
      if (who == 1 || who == 3) begin atk1 = a; valid1 = 1'b1; dodge2 = dg; end
      if (who == 2 || who == 3) begin atk2 = a; valid2 = 1'b1; dodge1 = dg; end
      step();
      step();
      clr_in();
      repeat (KB + 2) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int hits;

      //        a1     v1    d1    a2     v2    d2    hp1  hp2  b1     b2     h1    h2
      vt[0] = '{3'b001, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 200, 186, 2'b00, 2'b10, 1'b0, 1'b1};
      vt[1] = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 200, 193, 2'b00, 2'b01, 1'b0, 1'b1};
      vt[2] = '{3'b100, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 192, 180, 2'b10, 2'b10, 1'b1, 1'b1};
      vt[3] = '{3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 200, 200, 2'b00, 2'b00, 1'b0, 1'b0};
      vt[4] = '{3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 193, 200, 2'b01, 2'b00, 1'b1, 1'b0};
      vt[5] = '{3'b000, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 190, 200, 2'b01, 2'b00, 1'b1, 1'b0};
      vt[6] = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 200, 186, 2'b00, 2'b10, 1'b0, 1'b1};
      vt[7] = '{3'b110, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 200, 192, 2'b00, 2'b10, 1'b0, 1'b1};
      vt[8] = '{3'b001, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 200, 186, 2'b00, 2'b10, 1'b0, 1'b1};

      // Reset state
      do_reset();
      chk("rst_hp1", hp1, 200);
      chk("rst_hp2", hp2, 200);
      chk("rst_back", {back1, back2}, 0);
      chk("rst_hit", {hit1, hit2}, 0);
      chk("rst_flags", {p1win, p2win, draw}, 0);
      chk("rst_hp1x", hp1x, 75);
      chk("rst_hp2x", hp2x, 564);

      // Single-attack vectors, each from a fresh reset
      foreach (vt[i]) begin
         do_reset();
         atk1 = vt[i].a1; valid1 = vt[i].v1; dodge1 = vt[i].d1;
         atk2 = vt[i].a2; valid2 = vt[i].v2; dodge2 = vt[i].d2;
         step();
         step();
         chk($sformatf("v%0d_hp1", i), hp1, vt[i].e_hp1);
         chk($sformatf("v%0d_hp2", i), hp2, vt[i].e_hp2);
         chk($sformatf("v%0d_back1", i), back1, vt[i].e_b1);
         chk($sformatf("v%0d_back2", i), back2, vt[i].e_b2);
         chk($sformatf("v%0d_hit1", i), hit1, vt[i].e_h1);
         chk($sformatf("v%0d_hit2", i), hit2, vt[i].e_h2);
         chk($sformatf("v%0d_hp1x", i), hp1x, 275 - vt[i].e_hp1);
         chk($sformatf("v%0d_hp2x", i), hp2x, 364 + vt[i].e_hp2);
         clr_in();
         step();
         chk($sformatf("v%0d_hit_off", i), {hit1, hit2}, 0);
      end

      // Held button gives one hit; release and re-press gives a second
      do_reset();
      atk1 = 3'b001; valid1 = 1'b1;
      hits = 0;
      repeat (50) begin
         step();
         if (hit2 === 1'b1) hits++;
      end
      chk("hold_hits", hits, 1);
      chk("hold_hp2", hp2, 186);
      chk("hold_back2", back2, 2'b10);
      clr_in();
      repeat (3) step();
      chk("release_back2", back2, 2'b00);
      atk1 = 3'b001; valid1 = 1'b1;
      hits = 0;
      repeat (3) begin
         step();
         if (hit2 === 1'b1) hits++;
      end
      clr_in();
      repeat (12) begin
         step();
         if (hit2 === 1'b1) hits++;
      end
      chk("repress_hits", hits, 1);
      chk("repress_hp2", hp2, 172);

      // Request arriving during HOLD is dropped
      do_reset();
      atk1 = 3'b001; valid1 = 1'b1;
      step();
      step();
      clr_in();
      step();
      atk2 = 3'b100; valid2 = 1'b1;
      step();
      clr_in();
      repeat (KB + 4) step();
      chk("hold_ignore_hp1", hp1, 200);
      chk("hold_ignore_hp2", hp2, 186);

      // Game over: P1 brings P2 to 10, then a kick saturates to 0
      do_reset();
      repeat (9) attack(1, 3'b100, 1'b0);
      attack(1, 3'b100, 1'b1);
      chk("pre_over_hp2", hp2, 10);
      chk("pre_over_flags", {p1win, p2win, draw}, 0);
      attack(1, 3'b001, 1'b0);
      chk("over_hp2", hp2, 0);
      chk("over_flags", {p1win, p2win, draw}, 3'b100);
      chk("over_hp2x", hp2x, 364);
      attack(2, 3'b100, 1'b0);
      attack(1, 3'b001, 1'b0);
      chk("over_sticky_hp1", hp1, 200);
      chk("over_sticky_hp2", hp2, 0);
      chk("over_sticky_flags", {p1win, p2win, draw}, 3'b100);
      do_reset();
      chk("over_reset_hp2", hp2, 200);
      chk("over_reset_flags", {p1win, p2win, draw}, 0);

      // Draw: both at 20, simultaneous jumps land exactly on zero
      do_reset();
      repeat (9) attack(1, 3'b100, 1'b0);
      repeat (9) attack(2, 3'b100, 1'b0);
      chk("pre_draw_hp", {hp1, hp2}, {8'd20, 8'd20});
      attack(3, 3'b100, 1'b0);
      chk("draw_hp", {hp1, hp2}, 0);
      chk("draw_flags", {p1win, p2win, draw}, 3'b001);

      // Reset the cycle after acceptance aborts the attack
      do_reset();
      atk1 = 3'b001; valid1 = 1'b1;
      step();
      Reset = 1'b1;
      clr_in();
      #1;
      chk("abort_hp2_async", hp2, 200);
      step();
      Reset = 1'b0;
      repeat (3) step();
      chk("abort_hp", {hp1, hp2}, {8'd200, 8'd200});
      chk("abort_back", {back1, back2}, 0);
      chk("abort_hit", {hit1, hit2}, 0);
      attack(1, 3'b010, 1'b0);
      chk("abort_idle_hp2", hp2, 192);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
